// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator port responder.
//   cmd_e       : request command encodings
//   resp_e      : response encodings driven on out_resp
//   req_entry_t : one queued request (cmd, tag, operand 1, operand 2)
//   cap_state_e : request capture FSM states
//   eng_state_e : execution engine FSM states
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam int TAG_W  = 2;
    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;

    typedef enum logic [CMD_W-1:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        SHL = 4'd5,
        SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        OK   = 2'd1,
        ERR  = 2'd2
    } resp_e;

    // cmd is kept as raw bits: unknown encodings must survive the queue
    // so the ALU can flag them as invalid.
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } req_entry_t;

    typedef enum logic {
        CAP_IDLE,
        CAP_OP2
    } cap_state_e;

    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_EXEC,
        ENG_RESP
    } eng_state_e;

    function automatic logic is_shift(input logic [CMD_W-1:0] cmd);
        return (cmd == SHL) || (cmd == SHR);
    endfunction

endpackage

// File: rtl/calc_alu.sv
// ---------------------------------------------------------------------------
// calc_alu
// Purely combinational result/response generator for one request.
//   cmd    : request command
//   op1    : operand 1
//   op2    : operand 2 (shift amount taken from its 5 LSBs)
//   result : result, zero whenever resp is not OK
//   resp   : OK on success, ERR on carry/borrow or invalid command
// Optional feature macro: SHIFT_CMD_EN (enables SHL/SHR; otherwise they are
// invalid and no shifter exists).
// ---------------------------------------------------------------------------
module calc_alu
    import calc_pkg::*;
(
    input  logic [CMD_W-1:0]  cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] result,
    output resp_e             resp
);

    // One extra bit exposes carry (add) or borrow (sub) out of the MSB.
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, op1} + {1'b0, op2};
    assign diff = {1'b0, op1} - {1'b0, op2};

    always_comb begin
        result = '0;
        resp   = ERR;
        case (cmd)
            ADD: begin
                if (!sum[DATA_W]) begin
                    result = sum[DATA_W-1:0];
                    resp   = OK;
                end
            end
            SUB: begin
                if (!diff[DATA_W]) begin
                    result = diff[DATA_W-1:0];
                    resp   = OK;
                end
            end
`ifdef SHIFT_CMD_EN
            SHL: begin
                result = op1 << op2[4:0];
                resp   = OK;
            end
            SHR: begin
                result = op1 >> op2[4:0];
                resp   = OK;
            end
`endif
            default: begin
                result = '0;
                resp   = ERR;
            end
        endcase
    end

endmodule

// File: rtl/calc_port_responder.sv
// ---------------------------------------------------------------------------
// calc_port_responder
// Single-port calculator responder: captures two-cycle requests, queues them
// in order and executes them with fixed latencies, driving a one-cycle
// response per request.
//   clk      : clock
//   reset    : asynchronous active-low reset
//   req_cmd  : command, 0 = no request
//   req_tag  : request tag
//   req_data : operand 1 on the cmd cycle, operand 2 on the next cycle
//   out_resp : 0 none, 1 success, 2 overflow/underflow/invalid
//   out_tag  : tag of the responding request
//   out_data : result, 0 unless out_resp == 1
//   drop_err : sticky, a request was discarded because the queue was full
//   busy     : queue non-empty or engine active
// Optional feature macro: SHIFT_CMD_EN (shift commands with SHIFT_LAT latency).
// ---------------------------------------------------------------------------
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADD_LAT   = 2,
    parameter int SHIFT_LAT = 3
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [0:3]  req_cmd,
    input  logic [0:1]  req_tag,
    input  logic [0:31] req_data,
    output logic [0:1]  out_resp,
    output logic [0:1]  out_tag,
    output logic [0:31] out_data,
    output logic        drop_err,
    output logic        busy
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (ADD_LAT > SHIFT_LAT) ? ADD_LAT : SHIFT_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    // Capture FSM
    cap_state_e        cap_state_q, cap_state_d;
    logic [CMD_W-1:0]  cap_cmd_q, cap_cmd_d;
    logic [TAG_W-1:0]  cap_tag_q, cap_tag_d;
    logic [DATA_W-1:0] cap_op1_q, cap_op1_d;
    logic              push_valid;
    req_entry_t        push_entry;

    // Circular request queue
    req_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              full;
    logic              pop;
    logic              bypass;
    logic              write_en;

    // Engine
    eng_state_e        eng_q, eng_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_entry_t        cur_q, cur_d;
    logic [DATA_W-1:0] alu_result;
    resp_e             alu_resp;

    // Registered outputs
    logic [1:0]        out_resp_q, out_resp_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              drop_q, drop_d;

    function automatic logic [CNT_W-1:0] lat_m1(input logic [CMD_W-1:0] c);
`ifdef SHIFT_CMD_EN
        if (is_shift(c)) begin
            return CNT_W'(SHIFT_LAT - 1);
        end
`endif
        return CNT_W'(ADD_LAT - 1);
    endfunction

    always_comb begin : capture_fsm
        cap_state_d = cap_state_q;
        cap_cmd_d   = cap_cmd_q;
        cap_tag_d   = cap_tag_q;
        cap_op1_d   = cap_op1_q;
        case (cap_state_q)
            CAP_IDLE: begin
                if (req_cmd != '0) begin
                    cap_cmd_d   = req_cmd;
                    cap_tag_d   = req_tag;
                    cap_op1_d   = req_data;
                    cap_state_d = CAP_OP2;
                end
            end
            // Any command seen here only supplies operand 2.
            CAP_OP2:  cap_state_d = CAP_IDLE;
            default:  cap_state_d = CAP_IDLE;
        endcase
    end

    assign push_valid = (cap_state_q == CAP_OP2);
    assign push_entry = {cap_cmd_q, cap_tag_q, cap_op1_q, req_data};
    assign full       = (count_q == (PTR_W+1)'(DEPTH));

    calc_alu u_alu (
        .cmd    (cur_q.cmd),
        .op1    (cur_q.op1),
        .op2    (cur_q.op2),
        .result (alu_result),
        .resp   (alu_resp)
    );

    always_comb begin : engine_and_queue
        eng_d      = eng_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        out_resp_d = '0;
        out_tag_d  = '0;
        out_data_d = '0;
        pop        = 1'b0;
        bypass     = 1'b0;

        case (eng_q)
            ENG_IDLE, ENG_RESP: begin
                // An entry arriving into an empty queue goes straight to
                // the engine so an idle unit sees no extra latency.
                if (count_q != '0) begin
                    pop   = 1'b1;
                    cur_d = mem_q[rd_ptr_q];
                end else if (push_valid) begin
                    bypass = 1'b1;
                    cur_d  = push_entry;
                end
                if (pop || bypass) begin
                    eng_d = ENG_EXEC;
                    cnt_d = lat_m1(cur_d.cmd);
                end else begin
                    eng_d = ENG_IDLE;
                end
            end
            ENG_EXEC: begin
                if (cnt_q == '0) begin
                    eng_d      = ENG_RESP;
                    out_resp_d = alu_resp;
                    out_tag_d  = cur_q.tag;
                    out_data_d = alu_result;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: eng_d = ENG_IDLE;
        endcase

        // A pop on the same edge frees a slot for the incoming push.
        write_en = push_valid && !bypass && (!full || pop);
        drop_d   = drop_q | (push_valid && !bypass && !write_en);
        rd_ptr_d = pop      ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = write_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        case ({write_en, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_state_q <= CAP_IDLE;
            cap_cmd_q   <= '0;
            cap_tag_q   <= '0;
            cap_op1_q   <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            eng_q       <= ENG_IDLE;
            cnt_q       <= '0;
            cur_q       <= '0;
            out_resp_q  <= '0;
            out_tag_q   <= '0;
            out_data_q  <= '0;
            drop_q      <= 1'b0;
        end else begin
            cap_state_q <= cap_state_d;
            cap_cmd_q   <= cap_cmd_d;
            cap_tag_q   <= cap_tag_d;
            cap_op1_q   <= cap_op1_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            eng_q       <= eng_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            out_resp_q  <= out_resp_d;
            out_tag_q   <= out_tag_d;
            out_data_q  <= out_data_d;
            drop_q      <= drop_d;
        end
    end

    assign out_resp = out_resp_q;
    assign out_tag  = out_tag_q;
    assign out_data = out_data_q;
    assign drop_err = drop_q;
    assign busy     = (count_q != '0) || (eng_q != ENG_IDLE);

endmodule

// File: tb/tb_calc_port_responder.sv
// ---------------------------------------------------------------------------
// tb_calc_port_responder
// Self-checking bench: a nominal-latency instance runs a table of single
// requests plus hand-written sequences; a long-latency instance exercises
// queue overflow and reset during execution. Responses are matched against
// scoreboard queues filled when each request is driven.
// ---------------------------------------------------------------------------
module tb_calc_port_responder;

    localparam int LAT_ADD   = 2;
    localparam int LAT_SHIFT = 3;
    localparam int SLOW_LAT  = 12;
`ifdef SHIFT_CMD_EN
    localparam int LAT_SH = LAT_SHIFT;
    localparam bit SH_ON  = 1'b1;
`else
    localparam int LAT_SH = LAT_ADD;
    localparam bit SH_ON  = 1'b0;
`endif

    typedef struct {
        logic [1:0]  resp;
        logic [1:0]  tag;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  eresp;
        logic [31:0] edata;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset_m, reset_s;
    logic [0:3]  cmd_m, cmd_s;
    logic [0:1]  tag_m, tag_s;
    logic [0:31] data_m, data_s;
    logic [0:1]  resp_m, resp_s, otag_m, otag_s;
    logic [0:31] odata_m, odata_s;
    logic        drop_m, drop_s, busy_m, busy_s;

    int tests = 0;
    int fails = 0;
    int resp_cnt_m = 0, resp_cnt_s = 0;
    int last_cyc_m = 0, last_cyc_s = 0;
    exp_t exp_m[$];
    exp_t exp_s[$];

    calc_port_responder #(.DEPTH(4), .ADD_LAT(LAT_ADD), .SHIFT_LAT(LAT_SHIFT)) dut (
        .clk(clk), .reset(reset_m), .req_cmd(cmd_m), .req_tag(tag_m), .req_data(data_m),
        .out_resp(resp_m), .out_tag(otag_m), .out_data(odata_m),
        .drop_err(drop_m), .busy(busy_m)
    );

    calc_port_responder #(.DEPTH(4), .ADD_LAT(SLOW_LAT), .SHIFT_LAT(SLOW_LAT)) dut_slow (
        .clk(clk), .reset(reset_s), .req_cmd(cmd_s), .req_tag(tag_s), .req_data(data_s),
        .out_resp(resp_s), .out_tag(otag_s), .out_data(odata_s),
        .drop_err(drop_s), .busy(busy_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitors (sampled on the falling edge).
    always @(negedge clk) begin
        exp_t e;
        if (resp_m != 2'd0) begin
            resp_cnt_m++;
            last_cyc_m = cyc;
            $display("[TB] main cyc %0d resp %0d tag %0d data 0x%08h", cyc, resp_m, otag_m, odata_m);
            if (exp_m.size() == 0) begin
                check("main_unexpected_resp", 32'(resp_m), 32'd0);
            end else begin
                e = exp_m.pop_front();
                check("main_resp", 32'(resp_m), 32'(e.resp));
                check("main_tag", 32'(otag_m), 32'(e.tag));
                check("main_data", odata_m, e.data);
            end
        end else begin
            check("main_idle_zero", {30'd0, otag_m} | odata_m, 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (resp_s != 2'd0) begin
            resp_cnt_s++;
            last_cyc_s = cyc;
            $display("[TB] slow cyc %0d resp %0d tag %0d data 0x%08h", cyc, resp_s, otag_s, odata_s);
            if (exp_s.size() == 0) begin
                check("slow_unexpected_resp", 32'(resp_s), 32'd0);
            end else begin
                e = exp_s.pop_front();
                check("slow_resp", 32'(resp_s), 32'(e.resp));
                check("slow_tag", 32'(otag_s), 32'(e.tag));
                check("slow_data", odata_s, e.data);
            end
        end else begin
            check("slow_idle_zero", {30'd0, otag_s} | odata_s, 32'd0);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the operand-2 edge.
    task automatic send(input bit slow, input logic [3:0] c, input logic [1:0] t,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c2, output int pc);
        if (slow) begin cmd_s = c; tag_s = t; data_s = a; end
        else      begin cmd_m = c; tag_m = t; data_m = a; end
        @(posedge clk); #1;
        if (slow) begin cmd_s = c2; data_s = b; end
        else      begin cmd_m = c2; data_m = b; end
        @(posedge clk); #1;
        pc = cyc;
        if (slow) begin cmd_s = '0; tag_s = '0; data_s = '0; end
        else      begin cmd_m = '0; tag_m = '0; data_m = '0; end
    endtask

    task automatic wait_resp(input bit slow, input int target, input int budget);
        int n = 0;
        while (((slow ? resp_cnt_s : resp_cnt_m) < target) && (n < budget)) begin
            @(negedge clk); #1;
            n++;
        end
        check(slow ? "slow_resp_arrived" : "main_resp_arrived",
              32'((slow ? resp_cnt_s : resp_cnt_m) >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        int pc;
        int base;

        reset_m = 1'b0; reset_s = 1'b0;
        cmd_m = '0; tag_m = '0; data_m = '0;
        cmd_s = '0; tag_s = '0; data_s = '0;

        vecs[0]  = '{4'h1, 2'd2, 32'h00000001, 32'h00000001, 2'd1, 32'h00000002, LAT_ADD};
        vecs[1]  = '{4'h1, 2'd1, 32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h00000000, LAT_ADD};
        vecs[2]  = '{4'h2, 2'd3, 32'h00000005, 32'h00000007, 2'd2, 32'h00000000, LAT_ADD};
        vecs[3]  = '{4'h2, 2'd0, 32'h00000007, 32'h00000005, 2'd1, 32'h00000002, LAT_ADD};
        vecs[4]  = '{4'h2, 2'd1, 32'h00000005, 32'h00000005, 2'd1, 32'h00000000, LAT_ADD};
        vecs[5]  = '{4'h1, 2'd3, 32'h7FFFFFFF, 32'h80000000, 2'd1, 32'hFFFFFFFF, LAT_ADD};
        vecs[6]  = '{4'h1, 2'd2, 32'h80000000, 32'h80000000, 2'd2, 32'h00000000, LAT_ADD};
        vecs[7]  = '{4'hF, 2'd0, 32'h00001234, 32'h00005678, 2'd2, 32'h00000000, LAT_ADD};
        vecs[8]  = '{4'h3, 2'd1, 32'h00000009, 32'h00000009, 2'd2, 32'h00000000, LAT_ADD};
        vecs[9]  = '{4'h4, 2'd2, 32'h00000001, 32'h00000001, 2'd2, 32'h00000000, LAT_ADD};
        vecs[10] = '{4'h5, 2'd2, 32'h00000001, 32'h00000004,
                     SH_ON ? 2'd1 : 2'd2, SH_ON ? 32'h00000010 : 32'h0, LAT_SH};
        vecs[11] = '{4'h6, 2'd3, 32'h80000000, 32'd31,
                     SH_ON ? 2'd1 : 2'd2, SH_ON ? 32'h00000001 : 32'h0, LAT_SH};
        // Only the 5 LSBs of operand 2 form the shift amount (0x24 -> 4).
        vecs[12] = '{4'h5, 2'd1, 32'h00000001, 32'h00000024,
                     SH_ON ? 2'd1 : 2'd2, SH_ON ? 32'h00000010 : 32'h0, LAT_SH};
        vecs[13] = '{4'h6, 2'd0, 32'hF0000000, 32'hFFFFFFE4,
                     SH_ON ? 2'd1 : 2'd2, SH_ON ? 32'h0F000000 : 32'h0, LAT_SH};

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_resp", 32'(resp_m), 32'd0);
        check("reset_out_tag", 32'(otag_m), 32'd0);
        check("reset_out_data", odata_m, 32'd0);
        check("reset_drop_err", 32'(drop_m), 32'd0);
        check("reset_busy", 32'(busy_m), 32'd0);
        reset_m = 1'b1;
        reset_s = 1'b1;
        @(posedge clk); #1;

        // Table: one request at a time into an idle unit.
        for (int i = 0; i < 14; i++) begin
            exp_m.push_back('{vecs[i].eresp, vecs[i].tag, vecs[i].edata});
            base = resp_cnt_m;
            send(1'b0, vecs[i].cmd, vecs[i].tag, vecs[i].op1, vecs[i].op2, 4'h0, pc);
            wait_resp(1'b0, base + 1, 20);
            check($sformatf("vec%0d_latency", i), 32'(last_cyc_m - pc), 32'(vecs[i].lat));
            @(negedge clk); #1;
            check($sformatf("vec%0d_pulse_width", i), 32'(resp_m), 32'd0);
            check($sformatf("vec%0d_busy_after", i), 32'(busy_m), 32'd0);
            @(posedge clk); #1;
        end

        // Back-to-back overflow then underflow: order and tags kept.
        base = resp_cnt_m;
        exp_m.push_back('{2'd2, 2'd1, 32'h0});
        exp_m.push_back('{2'd2, 2'd3, 32'h0});
        send(1'b0, 4'h1, 2'd1, 32'hFFFFFFFF, 32'h1, 4'h0, pc);
        send(1'b0, 4'h2, 2'd3, 32'h5, 32'h7, 4'h0, pc);
        wait_resp(1'b0, base + 2, 30);
        @(posedge clk); #1;

        // Non-zero cmd during the operand-2 cycle is not a new request.
        base = resp_cnt_m;
        exp_m.push_back('{2'd2, 2'd0, 32'h0});
        send(1'b0, 4'hF, 2'd0, 32'h11, 32'h22, 4'h1, pc);
        wait_resp(1'b0, base + 1, 20);
        check("op2_cmd_latency", 32'(last_cyc_m - pc), 32'(LAT_ADD));
        repeat (10) @(posedge clk);
        #1;
        check("op2_cmd_single_resp", 32'(resp_cnt_m - base), 32'd1);
        check("main_drop_err_clear", 32'(drop_m), 32'd0);

        // Slow instance: six requests while the first is executing.
        base = resp_cnt_s;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_s.push_back('{2'd1, 2'(i), 32'(110 + i)});
            if (i == 5) check("slow_drop_before_full", 32'(drop_s), 32'd0);
            send(1'b1, 4'h1, 2'(i), 32'(100 + i), 32'd10, 4'h0, pc);
        end
        check("slow_drop_set", 32'(drop_s), 32'd1);
        wait_resp(1'b1, base + 5, 5 * (SLOW_LAT + 2) + 20);
        repeat (2 * SLOW_LAT) @(posedge clk);
        #1;
        check("slow_resp_count", 32'(resp_cnt_s - base), 32'd5);
        check("slow_drop_sticky", 32'(drop_s), 32'd1);
        check("slow_scoreboard_empty", 32'(exp_s.size()), 32'd0);

        // Reset while executing with two entries queued.
        send(1'b1, 4'h1, 2'd0, 32'h1, 32'h1, 4'h0, pc);
        send(1'b1, 4'h1, 2'd1, 32'h2, 32'h2, 4'h0, pc);
        send(1'b1, 4'h1, 2'd2, 32'h3, 32'h3, 4'h0, pc);
        repeat (2) @(posedge clk);
        #1;
        check("slow_busy_before_reset", 32'(busy_s), 32'd1);
        #2;
        reset_s = 1'b0;
        #1;
        check("reset_async_resp", 32'(resp_s), 32'd0);
        check("reset_async_busy", 32'(busy_s), 32'd0);
        check("reset_async_drop", 32'(drop_s), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_s = 1'b1;
        base = resp_cnt_s;
        repeat (3 * (SLOW_LAT + 1) + 5) @(posedge clk);
        #1;
        check("no_resp_after_reset", 32'(resp_cnt_s - base), 32'd0);

        base = resp_cnt_s;
        exp_s.push_back('{2'd1, 2'd2, 32'd7});
        send(1'b1, 4'h1, 2'd2, 32'd3, 32'd4, 4'h0, pc);
        wait_resp(1'b1, base + 1, SLOW_LAT + 10);
        check("post_reset_latency", 32'(last_cyc_s - pc), 32'(SLOW_LAT));
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/calc_port_responder.md
Name: calc_port_responder

Overview:
- Single-port calculator responder: accepts the request side of one calc port (cmd/tag/data, two-cycle operand transfer) and drives the response side (resp/tag/data).
- Sits opposite the bench's request driver. It serves as a synthesizable golden model and as a loopback target when the bench is brought up without the real DUT.
- Requests are queued and executed in order. Arithmetic and shift commands have fixed, parameterized latencies.

Parameters:
- DEPTH, 4, request queue entries (power of 2, 2..16)
- ADD_LAT, 2, clock edges from operand-2 sample to response for add/sub (>=1)
- SHIFT_LAT, 3, clock edges from operand-2 sample to response for shifts (>=1)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- req_cmd  input  [0:3]  command; 0 = no request
- req_tag  input  [0:1]  request tag
- req_data  input  [0:31]  operand 1 on cmd cycle; operand 2 on the following cycle
- out_resp  output  [0:1]  0 none, 1 success, 2 overflow/underflow/invalid, 3 never driven
- out_tag  output  [0:1]  tag of the responding request
- out_data  output  [0:31]  result; 0 when out_resp != 1
- drop_err  output  1  sticky; a request arrived while the queue was full
- busy  output  1  queue non-empty or engine active

Behaviour:
- Interface: one clock domain (clk); reset is asynchronous and active-low.
- Reset (asynchronous assert, synchronous release): out_resp=0, out_tag=0, out_data=0, drop_err=0, busy=0. Capture FSM returns to IDLE, queue is emptied, engine is idled, and any in-flight result is discarded with no response.
- Capture FSM:
  - IDLE: req_cmd!=0 latches cmd, tag and operand 1 -> OP2.
  - OP2: req_data is sampled as operand 2. The entry is pushed -> IDLE.
  - A req_cmd!=0 while in OP2 is ignored; its cycle still supplies operand 2.
- Queue full at the push cycle: the entry is discarded and drop_err is set. drop_err clears only on reset.
- Engine FSM:
  - IDLE: queue non-empty pops the head -> EXEC, loading the counter with (ADD_LAT or SHIFT_LAT) - 1.
  - EXEC: counts down to 0 -> RESP.
  - RESP: drives the response for exactly one cycle.
  - From RESP, a non-empty queue pops the next entry (back-to-back); otherwise -> IDLE.
- Latency with empty queue and idle engine: out_resp goes non-zero exactly LAT edges after the edge that samples operand 2. A push and a pop on the same edge with an empty queue bypass the queue, so latency is unchanged.
- Simultaneous push and pop with a full queue: the pop frees the slot first, so the push is accepted.
- Commands:
  - 1 add: carry out of bit 0 -> resp 2.
  - 2 sub: op2 > op1 (unsigned) -> resp 2.
  - 5 shift left, 6 shift right (logical), amount op2[27:31].
  - Any other non-zero cmd: resp 2 after ADD_LAT.
- Arithmetic is 33-bit unsigned; the result is truncated to [0:31]. Wrap-around is never reported as success.
- Duplicate tags in flight are permitted; responses are strictly in request order.
- out_resp/out_tag/out_data are 0 on every cycle the engine is not in RESP.

Optional Feature:
- Macro SHIFT_CMD_EN.
- Defined: cmds 5/6 execute as above with SHIFT_LAT latency.
- Undefined: cmds 5/6 are treated as invalid (resp 2, ADD_LAT latency). The SHIFT_LAT parameter is retained but unused, and no shifter is synthesized.

Decomposition:
- calc_pkg:
  - cmd_e enum (NOP=0, ADD=1, SUB=2, SHL=5, SHR=6)
  - resp_e enum (NONE=0, OK=1, ERR=2)
  - req_entry_t struct (cmd, tag, op1, op2)
  - localparams TAG_W=2, DATA_W=32, CMD_W=4
- Sub-module calc_alu: purely combinational. It takes cmd/op1/op2 and produces result and resp_e. It is registered at the RESP transition by the parent.
- Queue is implemented inline as a circular buffer with wrapping read/write pointers plus a count.

Test Plan:
- Add 0x00000001+0x00000001, tag 2, idle unit -> out_resp=1, out_tag=2, out_data=0x00000002 exactly 2 edges after operand-2 sample; single-cycle pulse.
- Add 0xFFFFFFFF+0x00000001 tag 1; then sub 0x00000005-0x00000007 tag 3 -> both out_resp=2, out_data=0, responses in order with tags 1 then 3.
- SHIFT_CMD_EN defined: shl 0x00000001 by 4 -> data 0x00000010 after 3 edges; shr 0x80000000 by 31 -> 0x00000001. Undefined: cmd 5 -> resp 2 after 2 edges.
- Six requests back-to-back (12 cycles) while the engine is stalled on the first -> 4 queued plus 1 in engine accepted, 6th dropped. drop_err=1 stays set; exactly 5 responses appear in order.
- Invalid cmd 0xF with tag 0 -> resp 2, tag 0, data 0 after 2 edges; a non-zero cmd during the OP2 cycle is ignored and only one response is produced.
- Reset asserted during EXEC with 2 entries queued -> outputs 0 immediately and no response after release. A new add 3+4 then returns 7 with nominal latency.
